// File: rtl/fuzz_stim_sequencer.sv
// Fuzz-harness stimulus sequencer: regenerates the LCG word stream, packs it into in_flat,
// holds each vector for HOLD_CYC clocks and folds every sampled out_flat into a 32-bit MISR.
module fuzz_stim_sequencer #(
    parameter int unsigned IN_W      = 136,
    parameter int unsigned OUT_W     = 159,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned HOLD_CYC  = 1,
    parameter logic [31:0] MISR_POLY = 32'h04C1_1DB7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] cycles,
    input  logic [OUT_W-1:0] out_flat,
    output logic [IN_W-1:0]  in_flat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [31:0]      sig
);

    localparam int unsigned WORDS     = (IN_W + 31) / 32;
    localparam int unsigned OUT_WORDS = (OUT_W + 31) / 32;
    localparam int unsigned OPAD_W    = OUT_WORDS * 32;
    localparam int unsigned WORD_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [31:0] LCG_A     = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_C     = 32'h0000_3039;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       w_launch;
    logic                       w_fill;
    logic                       w_load;
    logic                       w_sig_en;

    logic [31:0]                r_lcg;
    logic [CNT_W-1:0]           r_cycles;
    logic [WORD_W-1:0]          r_word;
    logic [HOLD_W-1:0]          r_hold;
    logic [WORDS-1:0][31:0]     r_shadow;
    logic [IN_W-1:0]            r_in_flat;
    logic [CNT_W-1:0]           r_vec_cnt;
    logic [31:0]                r_sig;
    logic                       r_busy;
    logic                       r_done;

    logic [31:0]                w_lcg_next;
    logic [WORDS-1:0][31:0]     w_shadow_full;
    logic [OPAD_W-1:0]          w_out_pad;
    logic [31:0]                w_fold;
    logic [31:0]                w_sig_next;

    assign w_lcg_next = r_lcg * LCG_A + LCG_C;

    // Shadow image with the word being generated this cycle already merged in
    always_comb begin
        w_shadow_full         = r_shadow;
        w_shadow_full[r_word] = w_lcg_next;
    end

    always_comb begin
        w_out_pad = OPAD_W'(out_flat);
        w_fold    = '0;
        for (int unsigned k = 0; k < OUT_WORDS; k++) begin
            w_fold = w_fold ^ w_out_pad[32*k +: 32];
        end
    end

    assign w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ w_fold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_fill   = 1'b0;
        w_load   = 1'b0;
        w_sig_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = (cycles == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                w_fill = 1'b1;
                if (r_word == WORD_W'(WORDS - 1)) begin
                    w_load = 1'b1;
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold == HOLD_W'(HOLD_CYC - 1)) begin
                    w_sig_en = 1'b1;
                    w_next   = (r_vec_cnt == r_cycles) ? S_DONE : S_FILL;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort dominates everything, including a simultaneous start
        if (abort) begin
            w_next   = S_IDLE;
            w_launch = 1'b0;
            w_fill   = 1'b0;
            w_load   = 1'b0;
            w_sig_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcg     <= '0;
            r_cycles  <= '0;
            r_word    <= '0;
            r_hold    <= '0;
            r_shadow  <= '0;
            r_in_flat <= '0;
            r_vec_cnt <= '0;
            r_sig     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_launch) begin
                r_lcg     <= seed;
                r_cycles  <= cycles;
                r_vec_cnt <= '0;
                r_sig     <= '0;
            end
            if (w_fill) begin
                r_lcg    <= w_lcg_next;
                r_shadow <= w_shadow_full;
            end
            if (w_load) begin
                r_in_flat <= IN_W'(w_shadow_full);
                r_vec_cnt <= r_vec_cnt + CNT_W'(1);
            end
            if (w_sig_en) r_sig <= w_sig_next;
            r_word <= (w_fill && !w_load) ? r_word + WORD_W'(1) : '0;
            r_hold <= (r_state == S_HOLD && w_next == S_HOLD) ? r_hold + HOLD_W'(1) : '0;
            r_busy <= (w_next == S_FILL) || (w_next == S_HOLD);
            r_done <= (w_next == S_DONE);
        end
    end

    assign in_flat = r_in_flat;
    assign busy    = r_busy;
    assign done    = r_done;
    assign vec_cnt = r_vec_cnt;
    assign sig     = r_sig;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
// Scoreboard bench for fuzz_stim_sequencer: a golden LCG/MISR model queues expected vectors,
// a monitor pops them each time vec_cnt advances, and run-end checks cover sig, count and timing.
module tb_fuzz_stim_sequencer;

    localparam int unsigned IN_W  = 136;
    localparam int unsigned OUT_W = 159;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned VPER  = 6;
    localparam logic [OUT_W-1:0] LB_MASK = OUT_W'({5{32'hA5C3_0F96}});

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      seed = '0;
    logic [CNT_W-1:0] cycles = '0;
    logic [OUT_W-1:0] out_flat;
    logic [IN_W-1:0]  in_flat;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [31:0]      sig;
    logic             loop_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IN_W-1:0] q_vec[$];
    logic [31:0]     m_sig;
    logic [31:0]     m_sig1;
    logic [IN_W-1:0] m_vec1;

    fuzz_stim_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .seed     (seed),
        .cycles   (cycles),
        .out_flat (out_flat),
        .in_flat  (in_flat),
        .busy     (busy),
        .done     (done),
        .vec_cnt  (vec_cnt),
        .sig      (sig)
    );

    always #5 clk = ~clk;

    always_comb out_flat = loop_en ? ({in_flat[22:0], in_flat} ^ LB_MASK) : '0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'h41C6_4E6D + 32'h0000_3039;
    endfunction

    function automatic logic [31:0] fold(input logic [OUT_W-1:0] o);
        logic [159:0] p;
        logic [31:0]  f;
        p = 160'(o);
        f = '0;
        for (int k = 0; k < 5; k++) f = f ^ p[32*k +: 32];
        return f;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    endfunction

    // Golden model: queue every vector the run should apply and track the expected signature
    task automatic model_run(input logic [31:0] sd, input int n, input logic lb);
        logic [31:0]     x;
        logic [159:0]    t;
        logic [IN_W-1:0] v;
        x     = sd;
        m_sig = '0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 5; k++) begin
                x = lcg(x);
                t[32*k +: 32] = x;
            end
            v = t[IN_W-1:0];
            q_vec.push_back(v);
            m_sig = misr(m_sig, fold(lb ? ({v[22:0], v} ^ LB_MASK) : '0));
            if (i == 0) begin
                m_sig1 = m_sig;
                m_vec1 = v;
            end
        end
    endtask

    // Returns one time unit after E0; seed/cycles are scrambled after E0
    task automatic launch(input logic [31:0] sd, input int n, input logic lb);
        loop_en = lb;
        model_run(sd, n, lb);
        @(negedge clk);
        seed   = sd;
        cycles = CNT_W'(n);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        seed   = $urandom;
        cycles = $urandom;
    endtask

    task automatic wait_done(input int n, input int pre, input string tag);
        int cnt;
        int lat;
        cnt = pre;
        lat = (n == 0) ? 0 : VPER * n;
        while (done !== 1'b1 && cnt < lat + 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_eq({tag, "_lat"}, cnt, lat);
        check_eq({tag, "_vec_cnt"}, vec_cnt, n);
        check_eq({tag, "_sig"}, sig, m_sig);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_sb_drain"}, q_vec.size(), 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, done, 0);
    endtask

    // Monitor: every advance of vec_cnt must present the next golden vector
    initial begin
        logic [CNT_W-1:0] prev;
        logic [IN_W-1:0]  exp_v;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (vec_cnt != prev && vec_cnt != '0) begin
                if (q_vec.size() == 0) begin
                    check_eq("unexpected_vec", vec_cnt, 0);
                end else begin
                    exp_v = q_vec.pop_front();
                    check_eq("in_flat", in_flat, exp_v);
                    check_eq("vec_cnt_step", vec_cnt, prev + 1);
                end
            end
            prev = vec_cnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        logic busy_seen;
        logic done_seen;

        #12;
        check_eq("rst_in_flat", in_flat, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_vec_cnt", vec_cnt, 0);
        check_eq("rst_sig", sig, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-length run
        launch(32'h0000_0005, 0, 1'b0);
        check_eq("t2_busy", busy, 0);
        check_eq("t2_done", done, 1);
        wait_done(0, 0, "t2");
        check_eq("t2_in_flat", in_flat, 0);

        // single vector from seed 0
        launch(32'h0, 1, 1'b0);
        check_eq("t1_busy", busy, 1);
        wait_done(1, 0, "t1");
        check_eq("t1_word0", in_flat[31:0], 32'h0000_3039);
        check_eq("t1_word1", in_flat[63:32], 32'hD3DC_167E);

        // long run, response tied low
        launch(32'hEFA6_9F08, 200, 1'b0);
        wait_done(200, 0, "t3");

        // loopback response folded into the signature
        launch(32'h1357_9BDF, 3, 1'b1);
        wait_done(3, 0, "t4");

        // abort in the second FILL cycle of vector 2
        launch(32'hCAFE_0001, 4, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_vec_cnt", vec_cnt, 1);
        check_eq("t5_in_flat", in_flat, m_vec1);
        check_eq("t5_sig", sig, m_sig1);
        done_seen = done;
        repeat (8) begin
            @(posedge clk);
            #1;
            done_seen = done_seen | done;
        end
        check_eq("t5_no_done", done_seen, 0);
        q_vec.delete();
        launch(32'hCAFE_0001, 2, 1'b1);
        wait_done(2, 0, "t5_rerun");

        // async reset during HOLD of vector 1
        launch(32'h0BAD_F00D, 3, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_in_flat", in_flat, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_vec_cnt", vec_cnt, 0);
        check_eq("t6_rst_sig", sig, 0);
        q_vec.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // start pulse while busy must not disturb the run
        launch(32'h1234_5678, 2, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        seed  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2, 3, "t6_busy_start");

        // start and abort together in IDLE: nothing launches
        @(negedge clk);
        start  = 1'b1;
        abort  = 1'b1;
        seed   = 32'h7777_7777;
        cycles = CNT_W'(5);
        busy_seen = 1'b0;
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            busy_seen = busy_seen | busy;
            done_seen = done_seen | done;
        end
        start = 1'b0;
        abort = 1'b0;
        check_eq("t6_sa_busy", busy_seen, 0);
        check_eq("t6_sa_done", done_seen, 0);
        check_eq("t6_sa_vec_cnt", vec_cnt, 2);
        check_eq("t6_sa_sig", sig, m_sig);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
